// File: rtl/ccr_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccr_unit_pkg
//  Description : Shared constants for the condition-code register unit:
//                flag bit positions and jump-condition encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ccr_unit_pkg;

    localparam int CCR_W  = 3;

    // Bit positions of the flags inside the 3-bit CCR word
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // Jump-condition field encodings
    typedef enum logic [1:0] {
        JC_Z      = 2'd0,
        JC_N      = 2'd1,
        JC_C      = 2'd2,
        JC_ALWAYS = 2'd3
    } jcond_e;

endpackage
`default_nettype wire

// File: rtl/ccr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ccr_stack
//  Description : Small LIFO for saved CCR words. Push when full and pop when
//                empty are ignored (the parent flags those as errors).
//                Simultaneous push and pop replaces the top entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccr_stack #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

    // Occupancy counter: only a lone push or a lone pop changes the depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (push && !pop && !full) begin
            r_count <= r_count + CW'(1);
        end else if (pop && !push && !empty) begin
            r_count <= r_count - CW'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        // Slot i takes a lone push into the next free slot, or a replace of the current top
        always_ff @(posedge clk) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (push && !pop && (r_count == CW'(i))) begin
                r_mem[i] <= din;
            end else if (push && pop && (r_count == CW'(i + 1))) begin
                r_mem[i] <= din;
            end
        end
    end

    // Top-of-stack mux; reads as zero while empty
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_count == CW'(i + 1)) begin
                top = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ccr_unit
//  Description : Condition-code register (Z/N/C). Applies ALU flag updates,
//                set/clear-carry, consumes flags on taken conditional jumps,
//                and saves/restores the flags on interrupt entry and RTI.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccr_unit
    import ccr_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CCR_W-1:0] alu_ccr,
    input  logic             alu_we,
    input  logic [CCR_W-1:0] alu_mask,
    input  logic             setc,
    input  logic             clrc,
    input  logic             jmp_valid,
    input  logic [1:0]       jmp_cond,
    input  logic             int_save,
    input  logic             rti_restore,
    output logic [CCR_W-1:0] ccr,
    output logic             jmp_taken,
    output logic             stack_err
);

    logic [CCR_W-1:0] r_ccr;
    logic             r_err;

    logic             w_taken;
    logic [CCR_W-1:0] w_consume;
    logic [CCR_W-1:0] w_work;
    logic [CCR_W-1:0] w_top;
    logic [CCR_W-1:0] w_push_data;
    logic             w_full;
    logic             w_empty;

    // Jump resolution against the registered flags; a taken conditional jump consumes its flag
    always_comb begin
        w_taken   = 1'b0;
        w_consume = '0;
        if (jmp_valid) begin
            case (jmp_cond)
                JC_Z: begin
                    w_taken           = r_ccr[FLAG_Z];
                    w_consume[FLAG_Z] = r_ccr[FLAG_Z];
                end
                JC_N: begin
                    w_taken           = r_ccr[FLAG_N];
                    w_consume[FLAG_N] = r_ccr[FLAG_N];
                end
                JC_C: begin
                    w_taken           = r_ccr[FLAG_C];
                    w_consume[FLAG_C] = r_ccr[FLAG_C];
                end
                default: begin
                    w_taken = 1'b1;
                end
            endcase
        end
    end

    // Working copy: jump consume, then masked ALU write, then set/clear carry (clear wins)
    always_comb begin
        w_work = r_ccr & ~w_consume;
        if (alu_we) begin
            w_work = (w_work & ~alu_mask) | (alu_ccr & alu_mask);
        end
        if (setc) begin
            w_work[FLAG_C] = 1'b1;
        end
        if (clrc) begin
            w_work[FLAG_C] = 1'b0;
        end
    end

    // Push+pop together rewrites the top with itself, so the stack is left intact
    assign w_push_data = rti_restore ? w_top : w_work;

    ccr_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (CCR_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (int_save),
        .pop   (rti_restore),
        .din   (w_push_data),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    // Flag register and sticky stack-error; restore overrides all normal updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ccr <= '0;
            r_err <= 1'b0;
        end else if (rti_restore && int_save) begin
            r_ccr <= w_top;
        end else if (rti_restore) begin
            if (w_empty) begin
                r_ccr <= '0;
                r_err <= 1'b1;
            end else begin
                r_ccr <= w_top;
            end
        end else begin
            r_ccr <= w_work;
            if (int_save && w_full) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ccr       = r_ccr;
    assign jmp_taken = w_taken;
    assign stack_err = r_err;

endmodule
`default_nettype wire
